// File: rtl/ogr_job_scheduler.sv
// rtl/ogr_job_scheduler.sv - dispatches search jobs to free engines and serialises their results
// Per-engine slots track IDLE/RUNNING/DONE; a round-robin arbiter drains DONE slots into one output register.
module ogr_job_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int JOB_W       = 48,
  parameter int CNT_W       = 16,
  parameter int TAG_W       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [JOB_W-1:0]             job_data,
  output logic [NUM_ENGINES-1:0]       eng_start,
  output logic [JOB_W-1:0]             eng_job,
  input  logic [NUM_ENGINES-1:0]       eng_done,
  input  logic [NUM_ENGINES*CNT_W-1:0] eng_count,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [63:0]                  res_data,
  output logic                         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic [1:0]       slot_state     [NUM_ENGINES];
  logic [1:0]       slot_state_nxt [NUM_ENGINES];
  logic [15:0]      slot_maxdist   [NUM_ENGINES];
  logic [TAG_W-1:0] slot_tag       [NUM_ENGINES];
  logic [CNT_W-1:0] slot_count     [NUM_ENGINES];
  logic [TAG_W-1:0] tag_cnt;
  logic [PTR_W-1:0] rr_ptr;

  logic             disp_found;
  logic             accept;
  logic [PTR_W-1:0] disp_idx;
  logic             coll_found;
  logic             collect;
  logic [PTR_W-1:0] coll_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             any_idle_nxt;
  logic             any_active;

  // Descending scan so the lowest-index idle slot is the one left standing.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (slot_state[i] == S_IDLE) begin
        disp_found = 1'b1;
        disp_idx   = PTR_W'(i);
      end
    end
  end

  assign accept = job_valid && job_ready && disp_found;

  // Offsets scanned high to low from rr_ptr so the nearest DONE slot wins.
  always_comb begin
    coll_found = 1'b0;
    coll_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_ENGINES);
      if (slot_state[scan_idx] == S_DONE) begin
        coll_found = 1'b1;
        coll_idx   = scan_idx;
      end
    end
  end

  assign collect = coll_found && (!res_valid || res_ready);

  always_comb begin
    any_idle_nxt = 1'b0;
    any_active   = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      slot_state_nxt[i] = slot_state[i];
      if (accept && disp_idx == PTR_W'(i)) begin
        slot_state_nxt[i] = S_RUN;
      end else if (slot_state[i] == S_RUN && eng_done[i]) begin
        slot_state_nxt[i] = S_DONE;
      end else if (collect && coll_idx == PTR_W'(i)) begin
        slot_state_nxt[i] = S_IDLE;
      end
      if (slot_state_nxt[i] == S_IDLE) any_idle_nxt = 1'b1;
      if (slot_state[i] != S_IDLE) any_active = 1'b1;
    end
  end

  assign busy = any_active || res_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_state[i]   <= S_IDLE;
        slot_maxdist[i] <= '0;
        slot_tag[i]     <= '0;
        slot_count[i]   <= '0;
      end
      tag_cnt   <= '0;
      rr_ptr    <= '0;
      job_ready <= 1'b0;
      eng_start <= '0;
      eng_job   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      job_ready <= any_idle_nxt;
      eng_start <= '0;
      eng_job   <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_state[i] <= slot_state_nxt[i];
        if (slot_state[i] == S_RUN && eng_done[i]) begin
          slot_count[i] <= eng_count[i*CNT_W +: CNT_W];
        end
      end
      if (accept) begin
        eng_start              <= NUM_ENGINES'(1) << disp_idx;
        eng_job                <= job_data;
        slot_maxdist[disp_idx] <= job_data[15:0];
        slot_tag[disp_idx]     <= tag_cnt;
        tag_cnt                <= tag_cnt + 1'b1;
      end
      if (collect) begin
        res_valid <= 1'b1;
        res_data  <= {slot_maxdist[coll_idx], 16'(slot_count[coll_idx]),
                      16'(slot_tag[coll_idx]), 5'b0, 3'(coll_idx), 8'h00};
        rr_ptr    <= (coll_idx == PTR_W'(NUM_ENGINES - 1)) ? '0 : coll_idx + 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ogr_job_scheduler.sv
// tb/tb_ogr_job_scheduler.sv - directed and randomized checks of ogr_job_scheduler against a scoreboard model
module tb_ogr_job_scheduler;
  localparam int N  = 4;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            job_valid, job_ready, res_valid, res_ready, busy;
  logic [47:0]     job_data, eng_job;
  logic [N-1:0]    eng_start, eng_done;
  logic [N*CW-1:0] eng_count;
  logic [63:0]     res_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: accepted jobs in order, per-engine pending {maxdist, tag} and counts.
  logic [47:0] acc_q [$];
  logic [31:0] job_q [N][$];
  logic [15:0] cnt_q [N][$];
  int          timer [N];
  bit          running [N];
  logic [15:0] model_tag;
  logic [15:0] last_tag, prev_tag;
  int          gen_left, p_valid, p_ready, max_delay, n_acc, n_res;

  ogr_job_scheduler #(.NUM_ENGINES(N), .JOB_W(48), .CNT_W(CW), .TAG_W(16)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .eng_start(eng_start), .eng_job(eng_job), .eng_done(eng_done), .eng_count(eng_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] res_word(input logic [15:0] md, input logic [15:0] cnt,
                                           input logic [15:0] tag, input int e);
    return {md, cnt, tag, 5'b0, 3'(e), 8'h00};
  endfunction

  task automatic idle_in();
    job_valid = 1'b0;
    job_data  = '0;
    eng_done  = '0;
    eng_count = '0;
    res_ready = 1'b0;
  endtask

  task automatic model_clear();
    acc_q.delete();
    for (int i = 0; i < N; i++) begin
      job_q[i].delete();
      cnt_q[i].delete();
      running[i] = 1'b0;
      timer[i]   = 0;
    end
    model_tag = 16'd0;
    last_tag  = 16'd0;
    prev_tag  = 16'd0;
    n_acc     = 0;
    n_res     = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_in();
    reset = 1'b1;
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic push_jobs(input int n, input logic [47:0] base);
    for (int k = 0; k < n; k++) begin
      job_valid = 1'b1;
      job_data  = base + 48'(k);
      @(negedge clock);
    end
    job_valid = 1'b0;
    job_data  = '0;
  endtask

  // One cycle of randomized traffic: observe the last edge, then drive the next one.
  task automatic rand_cycle();
    int          e;
    logic [47:0] j;
    logic [15:0] c;
    logic [31:0] ent;
    @(negedge clock);
    if (eng_start != '0) begin
      e = 0;
      for (int i = 0; i < N; i++) if (eng_start[i]) e = i;
      check("start_onehot", 64'($onehot(eng_start)), 64'd1);
      if (acc_q.size() == 0) begin
        check("start_without_accept", 64'(eng_start), 64'd0);
      end else begin
        j = acc_q.pop_front();
        check("eng_job", 64'(eng_job), 64'(j));
      end
      job_q[e].push_back({eng_job[15:0], model_tag});
      model_tag = model_tag + 16'd1;
      timer[e]   = int'($urandom_range(0, max_delay));
      running[e] = 1'b1;
    end
    eng_done = '0;
    for (int i = 0; i < N; i++) begin
      if (running[i]) begin
        if (timer[i] == 0) begin
          c = 16'($urandom);
          eng_done[i] = 1'b1;
          eng_count[i*CW +: CW] = c;
          cnt_q[i].push_back(c);
          running[i] = 1'b0;
        end else begin
          timer[i]--;
        end
      end
    end
    job_valid = (gen_left > 0) && ($urandom_range(0, 99) < p_valid);
    if (job_valid) job_data = 48'({$urandom(), $urandom()});
    if (job_valid && job_ready) begin
      acc_q.push_back(job_data);
      gen_left--;
      n_acc++;
    end
    res_ready = ($urandom_range(0, 99) < p_ready);
    if (res_valid && res_ready) begin
      e = int'(res_data[10:8]);
      n_res++;
      prev_tag = last_tag;
      last_tag = res_data[31:16];
      if (e >= N) begin
        check("result_engine_id", 64'(e), 64'(N - 1));
      end else if (job_q[e].size() == 0 || cnt_q[e].size() == 0) begin
        check("unexpected_result", res_data, 64'd0);
      end else begin
        ent = job_q[e].pop_front();
        c   = cnt_q[e].pop_front();
        check("result", res_data, res_word(ent[31:16], c, ent[15:0], e));
      end
    end
  endtask

  function automatic int pending();
    int p;
    p = acc_q.size();
    for (int i = 0; i < N; i++) p += job_q[i].size();
    return p;
  endfunction

  task automatic drain(input string tag);
    int cyc;
    gen_left = 0;
    p_ready  = 100;
    cyc      = 0;
    while (pending() != 0 && cyc < 300) begin
      rand_cycle();
      cyc++;
    end
    check(tag, 64'(pending()), 64'd0);
    rand_cycle();
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_count"}, 64'(n_res), 64'(n_acc));
  endtask

  initial begin
    int ord [4] = '{2, 3, 0, 1};
    int s;
    int cyc;
    idle_in();
    model_clear();
    gen_left = 0; p_valid = 0; p_ready = 0; max_delay = 0;
    repeat (2) @(negedge clock);
    check("rst_job_ready", 64'(job_ready), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);
    check("rst_eng_job", 64'(eng_job), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("job_ready_after_reset", 64'(job_ready), 64'd1);

    // single job
    job_valid = 1'b1;
    job_data  = 48'h24;
    @(negedge clock);
    check("single_start", 64'(eng_start), 64'b0001);
    check("single_job", 64'(eng_job), 64'h24);
    idle_in();
    @(negedge clock);
    check("single_start_clear", 64'(eng_start), 64'd0);
    check("single_job_clear", 64'(eng_job), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    eng_done = 4'b0001;
    eng_count[0 +: CW] = 16'd5;
    @(negedge clock);
    eng_done = '0;
    check("single_not_yet", 64'(res_valid), 64'd0);
    @(negedge clock);
    check("single_res_valid", 64'(res_valid), 64'd1);
    check("single_res_data", res_data, 64'h0024_0005_0000_0000);
    res_ready = 1'b1;
    @(negedge clock);
    check("single_res_clear", 64'(res_valid), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // fill all engines, fifth job waits for a completion
    do_reset();
    job_valid = 1'b1;
    job_data  = {32'h5A5A_0000, 16'h0100};
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("fill_start", 64'(eng_start), 64'(1) << k);
      check("fill_job", 64'(eng_job), 64'({32'h5A5A_0000, 16'h0100} + 48'(k)));
      job_data = {32'h5A5A_0000, 16'h0100} + 48'(k + 1);
    end
    check("fill_full", 64'(job_ready), 64'd0);
    repeat (3) begin
      @(negedge clock);
      check("fill_hold_start", 64'(eng_start), 64'd0);
      check("fill_hold_ready", 64'(job_ready), 64'd0);
    end
    eng_done = 4'b0100;
    eng_count[2*CW +: CW] = 16'd7;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("fill_res", res_data, res_word(16'h0102, 16'd7, 16'd2, 2));
    check("fill_ready_back", 64'(job_ready), 64'd1);
    check("fill_no_same_cycle", 64'(eng_start), 64'd0);
    res_ready = 1'b1;
    @(negedge clock);
    check("fill_fifth_start", 64'(eng_start), 64'b0100);
    check("fill_fifth_job", 64'(eng_job), 64'({32'h5A5A_0000, 16'h0104}));
    job_valid = 1'b0;
    eng_done  = 4'b0100;
    eng_count[2*CW +: CW] = 16'd9;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("fill_fifth_res", res_data, res_word(16'h0104, 16'd9, 16'd4, 2));

    // simultaneous completions, RR pointer at 0 then at 2
    do_reset();
    res_ready = 1'b1;
    push_jobs(4, 48'h0200);
    eng_done = 4'b1111;
    for (int k = 0; k < 4; k++) eng_count[k*CW +: CW] = 16'h10 + 16'(k);
    @(negedge clock);
    eng_done = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("sim0_valid", 64'(res_valid), 64'd1);
      check("sim0_res", res_data, res_word(16'h0200 + 16'(k), 16'h10 + 16'(k), 16'(k), k));
    end
    push_jobs(4, 48'h0300);
    eng_done = 4'b0010;
    eng_count[1*CW +: CW] = 16'h21;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("sim_rr_move", res_data, res_word(16'h0301, 16'h21, 16'd5, 1));
    push_jobs(1, 48'h0304);
    check("sim_refill_start", 64'(eng_start), 64'b0010);
    eng_done = 4'b1111;
    for (int k = 0; k < 4; k++) eng_count[k*CW +: CW] = 16'h30 + 16'(k);
    @(negedge clock);
    eng_done = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      s = ord[k];
      check("sim2_res", res_data, res_word((s == 1) ? 16'h0304 : 16'h0300 + 16'(s),
                                           16'h30 + 16'(s), (s == 1) ? 16'd8 : 16'd4 + 16'(s), s));
    end

    // back-pressure on the output register
    do_reset();
    push_jobs(4, 48'h0400);
    eng_done = 4'b0010;
    eng_count[1*CW +: CW] = 16'h41;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("bp_first", res_data, res_word(16'h0401, 16'h41, 16'd1, 1));
    check("bp_slot_freed", 64'(job_ready), 64'd1);
    push_jobs(1, 48'h0404);
    check("bp_all_busy", 64'(job_ready), 64'd0);
    eng_done = 4'b0101;
    eng_count[0 +: CW]    = 16'h50;
    eng_count[2*CW +: CW] = 16'h52;
    @(negedge clock);
    eng_done = '0;
    repeat (10) begin
      @(negedge clock);
      check("bp_hold_data", res_data, res_word(16'h0401, 16'h41, 16'd1, 1));
      check("bp_hold_ready", 64'(job_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clock);
    check("bp_drain0", res_data, res_word(16'h0402, 16'h52, 16'd2, 2));
    @(negedge clock);
    check("bp_drain1", res_data, res_word(16'h0400, 16'h50, 16'd0, 0));
    @(negedge clock);
    check("bp_drained", 64'(res_valid), 64'd0);

    // asynchronous reset mid-operation
    do_reset();
    push_jobs(4, 48'h0500);
    eng_done = 4'b0001;
    eng_count[0 +: CW] = 16'd1;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("ar_pre_valid", 64'(res_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_job_ready", 64'(job_ready), 64'd0);
    check("ar_eng_start", 64'(eng_start), 64'd0);
    check("ar_eng_job", 64'(eng_job), 64'd0);
    check("ar_res_valid", 64'(res_valid), 64'd0);
    check("ar_res_data", res_data, 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    eng_done = 4'b1110;
    for (int k = 0; k < 4; k++) eng_count[k*CW +: CW] = 16'h60 + 16'(k);
    @(negedge clock);
    eng_done = '0;
    repeat (3) begin
      @(negedge clock);
      check("ar_stale_done", 64'(res_valid), 64'd0);
      check("ar_stale_busy", 64'(busy), 64'd0);
    end
    push_jobs(1, 48'h77);
    check("ar_next_start", 64'(eng_start), 64'b0001);
    eng_done = 4'b0001;
    eng_count[0 +: CW] = 16'd3;
    @(negedge clock);
    eng_done = '0;
    @(negedge clock);
    check("ar_next_res", res_data, res_word(16'h0077, 16'd3, 16'd0, 0));

    // randomized traffic against the scoreboard
    do_reset();
    p_valid = 70; p_ready = 60; max_delay = 5; gen_left = 300;
    for (int k = 0; k < 500; k++) rand_cycle();
    drain("rand_drain");

    // tag wrap: 65537 jobs completed immediately
    do_reset();
    p_valid = 100; p_ready = 100; max_delay = 0; gen_left = 65537;
    cyc = 0;
    while (gen_left > 0 && cyc < 70000) begin
      rand_cycle();
      cyc++;
    end
    check("wrap_all_accepted", 64'(gen_left), 64'd0);
    drain("wrap_drain");
    check("wrap_last_tag", 64'(last_tag), 64'h0000);
    check("wrap_prev_tag", 64'(prev_tag), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ogr_job_scheduler.md
Name: ogr_job_scheduler

Overview:
- Sits between the UART command FSM and a bank of NUM_ENGINES Golomb-ruler search engines (`assembly` instances).
- Accepts 48-bit search jobs (16-bit max distance + fixed-prefix marks) over a valid/ready interface and dispatches each job to a free engine.
- Captures each engine's done pulse and result count, then serialises completions through a round-robin arbiter into a single 64-bit result stream for the UART reply path.

Parameters:
- NUM_ENGINES, 4, number of search engines scheduled (1..8).
- JOB_W, 48, job word width; bits [15:0] are the max distance.
- CNT_W, 16, per-engine result-count width.
- TAG_W, 16, job sequence-tag width.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- job_valid  in  1  job_data holds a job.
- job_ready  out  1  scheduler can accept a job this cycle.
- job_data  in  JOB_W  job word.
- eng_start  out  NUM_ENGINES  one-hot, one-cycle start pulse.
- eng_job  out  JOB_W  shared job bus, valid while eng_start is non-zero.
- eng_done  in  NUM_ENGINES  per-engine one-cycle completion pulse.
- eng_count  in  NUM_ENGINES*CNT_W  per-engine result count, valid with eng_done; engine i uses slice [i*CNT_W +: CNT_W].
- res_valid  out  1  res_data holds a result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  64  {maxdist[15:0], count[15:0], tag[15:0], 5'b0, engine_id[2:0], 8'h00} (MSB first).
- busy  out  1  any engine not IDLE, or res_valid high.

Behaviour:
- Reset values: job_ready=0 while reset is asserted (1 from the first edge after release when NUM_ENGINES>0), eng_start=0, eng_job=0, res_valid=0, res_data=0, busy=0. Tag counter=0, all slots IDLE, RR pointer=0.
- Per-engine slot FSM:
  - IDLE -> RUNNING on dispatch.
  - RUNNING -> DONE on eng_done[i]; the count is latched into the slot at that edge.
  - DONE -> IDLE when the slot is moved into the output register.
  - eng_done[i] while the slot is IDLE or DONE is ignored.
- Slot storage: each slot holds maxdist[15:0], tag and count.
- job_ready (registered) = at least one IDLE slot. A slot freed this edge makes job_ready high next cycle, not same cycle.
- Accept and dispatch:
  - Accept on job_valid && job_ready.
  - The lowest-index IDLE slot is chosen and its tag is set to the current counter; the counter then increments mod 2^TAG_W.
  - eng_start[chosen] and eng_job=job_data are registered and appear 1 cycle after the accept edge, for exactly 1 cycle.
  - eng_job returns to 0 the following cycle.
- Collection:
  - The output register is free when !res_valid, or when res_valid && res_ready (the same-edge refill is allowed, giving full throughput).
  - When free and any slot is DONE, the first DONE slot at or after the RR pointer (wrapping) is loaded into res_data, res_valid is set, the slot goes IDLE, and the pointer becomes that index+1 mod NUM_ENGINES.
  - One transfer per cycle.
  - If nothing is DONE and res_ready is high, res_valid clears.
- Latency: eng_done edge -> res_valid high at the next edge (minimum 1 cycle) when the output register is free.
- Hold: while res_valid && !res_ready, res_data is stable and DONE slots wait. Engines do not back-pressure, so RUNNING slots keep accepting eng_done.
- Simultaneous events: accept, a completion and an output transfer can all occur in one cycle.
  - A slot transferring to output this cycle is not eligible for dispatch until the next cycle.
  - Multiple eng_done bits in the same cycle are all latched.
- Count width: the count is copied verbatim (CNT_W=16). For CNT_W<16 it is zero-extended.
- Tag wrap: 0xFFFF -> 0x0000 with no stall.
- Reset mid-operation clears all pending results; in-flight engines are abandoned, and their later done pulses hit IDLE slots and are ignored.

Test Plan:
- Single job: after reset, job_data=0x0000_0000_0024 valid 1 cycle -> eng_start=4'b0001 one cycle later with eng_job=0x...0024. eng_done[0] with count 5 -> res_data=0x0024_0005_0000_0000, res_valid 1 cycle later.
- Fill: 5 jobs back-to-back, no done -> eng_start pulses 0001,0010,0100,1000 on consecutive cycles with tags 0..3; job_ready=0 after the 4th accept; the 5th job is held until a completion.
- Simultaneous done: eng_done=4'b1111 in one cycle, res_ready=1 -> 4 results on 4 consecutive cycles with engine_id order 0,1,2,3. Repeat with the RR pointer at 2 -> order 2,3,0,1.
- Back-pressure: res_ready=0 for 10 cycles with 2 DONE slots -> res_data constant, no slot freed, job_ready=0 if all slots busy. Release -> both results drain in 2 cycles.
- Tag wrap: 65537 jobs, each completed immediately -> the last result tag=0x0000, the preceding one 0xFFFF.
- Async reset while 3 engines RUNNING and res_valid=1 -> all outputs 0 immediately without a clock edge. Subsequent eng_done pulses produce no result; the next job gets tag 0 on engine 0.
